fib_tp_ctrl: RTL and testbench

- Synchronous sequencer and checker for the asynchronous two-rail Fibonacci pipeline (fib_tp); on the FPGA top it replaces the manual VIO rst/ack drive.
- Resets the pipeline and generates its two-phase ack from clk.
- Samples and decodes each dual-rail output token, checks the Fibonacci recurrence, and reports counts and errors to the debug probes.

---
 rtl/fib_tp_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fib_tp_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fib_tp_ctrl.sv
// Clocked sequencer/checker for the two-rail Fibonacci pipeline: resets it, samples and
// decodes each dual-rail token, answers with a two-phase ack and checks the recurrence.
module fib_tp_ctrl #(
  parameter int WIDTH      = 8,
  parameter int RAIL_NUM   = 2,
  parameter int RST_CYCLES = 16,
  parameter int SETTLE     = 2,
  parameter int N_TOKENS   = 64,
  parameter int TMO_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           dp_rst,
  output logic                           ack_o,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0] in,
  output logic [WIDTH-1:0]               value,
  output logic                           value_vld,
  output logic [15:0]                    tok_cnt,
  output logic                           busy,
  output logic                           done,
  output logic                           err_seq,
  output logic                           err_tmo
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int TW  = $clog2(TMO_CYCLES + 1);
  localparam int SCW = $clog2(SETTLE + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_WAIT, S_SETTLE, S_ACK, S_DONE, S_ERR
  } state_t;

  state_t r_state, w_nxt;

  logic [WIDTH-1:0][RAIL_NUM-1:0] r_sync_p0, r_sync_p1, r_cap;
  logic [WIDTH-1:0] r_value, r_prev, r_prev2;
  logic [15:0]      r_tok_cnt;
  logic [RCW-1:0]   r_rcnt;
  logic [TW-1:0]    r_timer;
  logic [SCW-1:0]   r_stable;
  logic r_ph, r_ack, r_vld, r_dp_rst, r_busy, r_done, r_err_seq, r_err_tmo;

  logic [WIDTH-1:0] w_phase, w_cap_data, w_sum;
  logic [SCW-1:0]   w_stable_nxt;
  logic w_complete, w_same, w_bad, w_last, w_rst_end, w_tmo, w_settled;

  // Rail 1 carries the data bit; the XOR of both rails carries the token phase.
  always_comb begin
    w_phase    = '0;
    w_cap_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_phase[i]    = r_sync_p1[i][1] ^ r_sync_p1[i][0];
      w_cap_data[i] = r_cap[i][1];
    end
  end

  assign w_complete   = (w_phase == {WIDTH{r_ph}});
  assign w_same       = (r_sync_p1 == r_cap);
  assign w_sum        = r_prev + r_prev2;
  assign w_bad        = (r_tok_cnt >= 16'd2) && (w_cap_data != w_sum);
  assign w_last       = ((r_tok_cnt + 16'd1) == 16'(N_TOKENS));
  assign w_rst_end    = (r_rcnt == RCW'(RST_CYCLES - 1));
  assign w_tmo        = (r_timer == TW'(TMO_CYCLES - 1));
  assign w_stable_nxt = r_stable + SCW'(1);
  assign w_settled    = (w_stable_nxt >= SCW'(SETTLE));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_nxt = S_RESET;
      S_RESET:  if (w_rst_end) w_nxt = S_WAIT;
      S_WAIT: begin
        if (w_complete)  w_nxt = S_SETTLE;
        else if (w_tmo)  w_nxt = S_ERR;
      end
      S_SETTLE: begin
        if (!w_same)        w_nxt = S_WAIT;
        else if (w_settled) w_nxt = S_ACK;
      end
      S_ACK: begin
        if (w_bad)       w_nxt = S_ERR;
        else if (w_last) w_nxt = S_DONE;
        else             w_nxt = S_WAIT;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_cap     <= '0;
      r_value   <= '0;
      r_prev    <= '0;
      r_prev2   <= '0;
      r_tok_cnt <= '0;
      r_rcnt    <= '0;
      r_timer   <= '0;
      r_stable  <= '0;
      r_ph      <= 1'b0;
      r_ack     <= 1'b0;
      r_vld     <= 1'b0;
      r_dp_rst  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err_seq <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_sync_p0 <= in;
      r_sync_p1 <= r_sync_p0;
      r_state   <= w_nxt;
      // Status outputs follow the next state so they change on the same edge as the state.
      r_dp_rst  <= (w_nxt == S_IDLE) || (w_nxt == S_RESET) || (w_nxt == S_ERR);
      r_busy    <= (w_nxt == S_RESET) || (w_nxt == S_WAIT) ||
                   (w_nxt == S_SETTLE) || (w_nxt == S_ACK);
      r_done    <= (w_nxt == S_DONE);
      r_vld     <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_tok_cnt <= '0;
            r_err_seq <= 1'b0;
            r_err_tmo <= 1'b0;
            r_ph      <= 1'b1;
            r_ack     <= 1'b0;
            r_rcnt    <= '0;
            r_timer   <= '0;
            r_prev    <= '0;
            r_prev2   <= '0;
          end
        end
        S_RESET: r_rcnt <= r_rcnt + RCW'(1);
        S_WAIT: begin
          if (w_complete) begin
            r_cap    <= r_sync_p1;
            r_stable <= SCW'(1);
          end else if (w_tmo) begin
            r_err_tmo <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_SETTLE: if (w_same) r_stable <= w_stable_nxt;
        S_ACK: begin
          r_ack     <= ~r_ack;
          r_value   <= w_cap_data;
          r_vld     <= 1'b1;
          r_tok_cnt <= r_tok_cnt + 16'd1;
          r_ph      <= ~r_ph;
          r_timer   <= '0;
          r_prev2   <= r_prev;
          r_prev    <= w_cap_data;
          if (w_bad) r_err_seq <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dp_rst    = r_dp_rst;
  assign ack_o     = r_ack;
  assign value     = r_value;
  assign value_vld = r_vld;
  assign tok_cnt   = r_tok_cnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_seq   = r_err_seq;
  assign err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_fib_tp_ctrl.sv
// Bench for fib_tp_ctrl: a behavioural dual-rail pipeline model drives tokens and a
// reference built from the Fibonacci rule predicts every value, count and error.
module tb_fib_tp_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0][1:0]  rails;
  logic             dp_rst, ack_o, value_vld, busy, done, err_seq, err_tmo;
  logic [7:0]       value;
  logic [15:0]      tok_cnt;

  int total  = 0;
  int passed = 0;
  int nfail  = 0;
  int vld_cnt = 0;
  int tog_cnt = 0;
  logic ack_q = 1'b0;
  logic model_ph;
  logic [7:0] seq [64];

  fib_tp_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dp_rst(dp_rst), .ack_o(ack_o),
    .in(rails), .value(value), .value_vld(value_vld), .tok_cnt(tok_cnt),
    .busy(busy), .done(done), .err_seq(err_seq), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  // Independent monitor of accepted-token pulses and ack transitions.
  always @(negedge clk) begin
    if (value_vld === 1'b1) vld_cnt <= vld_cnt + 1;
    if (ack_o !== ack_q) tog_cnt <= tog_cnt + 1;
    ack_q <= ack_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // LEDR encoding: rail1 = data, rail0 = data ^ phase.
  function automatic logic [7:0][1:0] enc(input logic [7:0] v, input logic ph);
    logic [7:0][1:0] r;
    for (int b = 0; b < 8; b++) begin
      r[b][1] = v[b];
      r[b][0] = v[b] ^ ph;
    end
    return r;
  endfunction

  function automatic int first_bad(input int n);
    for (int i = 2; i < n; i++)
      if (seq[i] != 8'(seq[i-1] + seq[i-2])) return i;
    return -1;
  endfunction

  task automatic send_token(input logic [7:0] v, input int dly, output int lat);
    logic old;
    old = ack_o;
    repeat (dly) begin @(posedge clk); #1; end
    rails = enc(v, model_ph);
    lat = 0;
    while (ack_o === old && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    model_ph = ~model_ph;
  endtask

  task automatic launch(input string tag);
    int n;
    rails = '0;
    model_ph = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_cnt0"}, tok_cnt, 0);
    chk({tag, "_errs0"}, {err_seq, err_tmo}, 0);
    n = 0;
    while (dp_rst === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_dprst_len"}, n, 16);
  endtask

  task automatic run_seq(input int n, input string tag);
    int bad, lat;
    bad = first_bad(n);
    for (int i = 0; i < n; i++) begin
      send_token(seq[i], $urandom_range(0, 7), lat);
      chk({tag, "_lat"}, lat, 5);
      chk({tag, "_value"}, value, seq[i]);
      chk({tag, "_vld"}, value_vld, 1);
      chk({tag, "_tokcnt"}, tok_cnt, i + 1);
      chk({tag, "_errseq"}, err_seq, (i == bad) ? 1 : 0);
      if (i == bad) break;
    end
  endtask

  task automatic fib_fill(input logic [7:0] a, input logic [7:0] b);
    seq[0] = a;
    seq[1] = b;
    for (int i = 2; i < 64; i++) seq[i] = 8'(seq[i-1] + seq[i-2]);
  endtask

  initial begin
    int v0, t0, n, lat, g;
    logic old_ack;
    logic [7:0] gv;
    logic [7:0][1:0] w;

    rst = 1'b0; start = 1'b0; rails = '0; model_ph = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dprst", dp_rst, 1);
    chk("rst_ack", ack_o, 0);
    chk("rst_value", value, 0);
    chk("rst_vld", value_vld, 0);
    chk("rst_tokcnt", tok_cnt, 0);
    chk("rst_flags", {busy, done, err_seq, err_tmo}, 0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_dprst", dp_rst, 1);

    // Full run of true Fibonacci mod 256, first six tokens counted separately.
    launch("l1");
    fib_fill(8'd0, 8'd1);
    v0 = vld_cnt; t0 = tog_cnt;
    run_seq(6, "f6");
    @(posedge clk); #1;
    chk("f6_vld_pulses", vld_cnt - v0, 6);
    chk("f6_ack_toggles", tog_cnt - t0, 6);
    chk("f6_vld_low", value_vld, 0);
    for (int i = 6; i < 64; i++) begin
      send_token(seq[i], $urandom_range(0, 7), lat);
      chk("f64_lat", lat, 5);
      chk("f64_value", value, seq[i]);
      chk("f64_tokcnt", tok_cnt, i + 1);
      chk("f64_errseq", err_seq, 0);
    end
    chk("f64_done", done, 1);
    chk("f64_busy", busy, 0);
    chk("f64_dprst", dp_rst, 0);

    // Recurrence violation: literal 0,1,1,3.
    launch("l2");
    seq[0] = 8'd0; seq[1] = 8'd1; seq[2] = 8'd1; seq[3] = 8'd3;
    run_seq(4, "bad4");
    chk("bad4_errseq", err_seq, 1);
    chk("bad4_tokcnt", tok_cnt, 4);
    chk("bad4_dprst", dp_rst, 1);
    chk("bad4_busy", busy, 0);
    chk("bad4_done", done, 0);

    // Random seeds with a corruption at a random position.
    launch("l3");
    fib_fill(8'($urandom), 8'($urandom));
    g = $urandom_range(2, 7);
    seq[g] = seq[g] + 8'($urandom_range(1, 255));
    run_seq(10, "badr");
    chk("badr_tokcnt", tok_cnt, g + 1);
    chk("badr_errseq", err_seq, 1);

    // Stall after three tokens.
    launch("l4");
    fib_fill(8'($urandom), 8'($urandom));
    run_seq(3, "tmo");
    old_ack = ack_o;
    n = 0;
    while (err_tmo !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_cycles", n, 4096);
    chk("tmo_ack_hold", ack_o, old_ack);
    chk("tmo_dprst", dp_rst, 1);
    chk("tmo_tokcnt", tok_cnt, 3);
    chk("tmo_errseq", err_seq, 0);

    // Skewed rails with a one-cycle wrong-but-complete glitch on one bit.
    launch("l5");
    gv = 8'($urandom_range(1, 255));
    g = $urandom_range(0, 7);
    w = enc(gv, 1'b1);
    v0 = vld_cnt; t0 = tog_cnt;
    old_ack = ack_o;
    rails = w;
    rails[g] = 2'b00;
    @(posedge clk); #1;
    rails[g] = {~gv[g], gv[g]};
    @(posedge clk); #1;
    rails[g] = 2'b00;
    @(posedge clk); #1;
    rails[g] = w[g];
    n = 0;
    while (ack_o === old_ack && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("skew_value", value, gv);
    chk("skew_tokcnt", tok_cnt, 1);
    repeat (20) begin @(posedge clk); #1; end
    chk("skew_vld_pulses", vld_cnt - v0, 1);
    chk("skew_ack_toggles", tog_cnt - t0, 1);
    chk("skew_busy", busy, 1);

    // Asynchronous reset while waiting for the next token.
    #3 rst = 1'b0;
    #1;
    chk("arst_dprst", dp_rst, 1);
    chk("arst_ack", ack_o, 0);
    chk("arst_value", value, 0);
    chk("arst_vld", value_vld, 0);
    chk("arst_tokcnt", tok_cnt, 0);
    chk("arst_flags", {busy, done, err_seq, err_tmo}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    launch("l6");
    fib_fill(8'd0, 8'd1);
    v0 = vld_cnt; t0 = tog_cnt;
    run_seq(6, "re6");
    @(posedge clk); #1;
    chk("re6_vld_pulses", vld_cnt - v0, 6);
    chk("re6_ack_toggles", tog_cnt - t0, 6);
    chk("re6_tokcnt", tok_cnt, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
